// File: rtl/result_frame_acc_pkg.sv
// Shared types and width helpers for the result frame accumulator.
package result_frame_acc_pkg;

    // Frame controller states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StHold  = 2'd2
    } state_t;

    // Width of the frame-wide ones count: holds 0..FRAME_LEN*DATA_W.
    function automatic int unsigned sum_width(input int unsigned frame_len,
                                              input int unsigned data_w);
        return $clog2(frame_len * data_w + 1);
    endfunction

    // Width of the accepted-beat counter: holds 0..FRAME_LEN.
    function automatic int unsigned cnt_width(input int unsigned frame_len);
        return $clog2(frame_len + 1);
    endfunction

    // Width of a single-sample ones count: holds 0..DATA_W.
    function automatic int unsigned pc_width(input int unsigned data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/result_frame_acc_popcount_w.sv
// Combinational population count of one DATA_W-bit sample.
module popcount_w
    import result_frame_acc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    localparam int unsigned PC_W = pc_width(DATA_W)
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [PC_W-1:0]   o_count
);

    logic [PC_W-1:0] w_sum;

    // Sum the individual bits of the sample.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            w_sum = w_sum + PC_W'(i_data[i]);
        end
    end

    assign o_count = w_sum;

endmodule

// File: rtl/result_frame_acc.sv
// Accumulates popcount, AND and OR over a fixed-length frame of samples and
// presents a registered summary with a valid/ready handshake.
module result_frame_acc
    import result_frame_acc_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FRAME_LEN = 16,
    localparam int unsigned SUM_W = sum_width(FRAME_LEN, DATA_W),
    localparam int unsigned CNT_W = cnt_width(FRAME_LEN),
    localparam int unsigned PC_W  = pc_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [SUM_W-1:0]  out_popsum,
    output logic [DATA_W-1:0] out_and,
    output logic [DATA_W-1:0] out_or,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(FRAME_LEN - 1);

    state_t            r_state;
    logic [SUM_W-1:0]  r_popsum;
    logic [DATA_W-1:0] r_and;
    logic [DATA_W-1:0] r_or;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out_valid;
    logic [SUM_W-1:0]  r_out_popsum;
    logic [DATA_W-1:0] r_out_and;
    logic [DATA_W-1:0] r_out_or;

    logic [PC_W-1:0]   w_pc;
    logic [SUM_W-1:0]  w_popsum_nxt;
    logic [DATA_W-1:0] w_and_nxt;
    logic [DATA_W-1:0] w_or_nxt;

    popcount_w #(
        .DATA_W (DATA_W)
    ) u_popcount (
        .i_data  (in_data),
        .o_count (w_pc)
    );

    // Accumulator values including the beat on the input this cycle.
    always_comb begin
        w_popsum_nxt = r_popsum + SUM_W'(w_pc);
        w_and_nxt    = r_and & in_data;
        w_or_nxt     = r_or | in_data;
    end

    // Frame controller with accumulators and registered summary outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_popsum     <= '0;
            r_and        <= '0;
            r_or         <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_popsum <= '0;
            r_out_and    <= '0;
            r_out_or     <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state  <= StAccum;
                        r_popsum <= '0;
                        r_and    <= '1;
                        r_or     <= '0;
                        r_cnt    <= '0;
                    end
                end
                StAccum: begin
                    if (in_valid) begin
                        r_popsum <= w_popsum_nxt;
                        r_and    <= w_and_nxt;
                        r_or     <= w_or_nxt;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == LastCnt) begin
                            r_state      <= StHold;
                            r_out_valid  <= 1'b1;
                            r_out_popsum <= w_popsum_nxt;
                            r_out_and    <= w_and_nxt;
                            r_out_or     <= w_or_nxt;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (start) begin
                            // Back-to-back frame: reopen without passing IDLE.
                            r_state  <= StAccum;
                            r_popsum <= '0;
                            r_and    <= '1;
                            r_or     <= '0;
                            r_cnt    <= '0;
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready   = (r_state == StAccum);
    assign busy       = (r_state != StIdle);
    assign out_valid  = r_out_valid;
    assign out_popsum = r_out_popsum;
    assign out_and    = r_out_and;
    assign out_or     = r_out_or;

endmodule

// File: doc/result_frame_acc.md
RESULT_FRAME_ACC -- requirements
Module: result_frame_acc

Interface
REQ-001 Parameter DATA_W, default 8, width of the bitwise-result stream being consumed.
REQ-002 Parameter FRAME_LEN, default 16, number of accepted samples per frame; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to open a new frame.
REQ-006 in_valid  input  1  in_data carries a result sample.
REQ-007 in_data  input  DATA_W  bitwise logic-unit result (And/Or stage output).
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 out_ready  input  1  consumer accepts the frame summary.
REQ-010 out_valid  output  1  frame summary is valid and stable.
REQ-011 out_popsum  output  SUM_W  total count of 1-bits over the frame; SUM_W = clog2(FRAME_LEN*DATA_W+1).
REQ-012 out_and  output  DATA_W  bitwise AND of all frame samples.
REQ-013 out_or  output  DATA_W  bitwise OR of all frame samples.
REQ-014 busy  output  1  high in ACCUM or HOLD.

Function
REQ-015 The FSM SHALL have states IDLE, ACCUM, HOLD; IDLE after reset.
REQ-016 IDLE: in_ready=0, out_valid=0; start=1 -> ACCUM next cycle with popsum=0, and_acc=all ones, or_acc=0, cnt=0.
REQ-017 ACCUM: in_ready=1 combinationally from state; a beat is accepted when in_valid and in_ready are both 1.
REQ-018 Each accepted beat SHALL add popcount(in_data) to popsum, AND into and_acc, OR into or_acc, increment cnt (width clog2(FRAME_LEN+1)).
REQ-019 Cycles with in_valid=0 in ACCUM SHALL leave all accumulators unchanged; gaps of any length are legal.
REQ-020 The beat taking cnt to FRAME_LEN SHALL move the FSM to HOLD; out_valid SHALL be 1 on the very next cycle (latency 1 cycle from last accepted beat), with outputs reflecting that last beat.
REQ-021 start asserted in ACCUM or HOLD SHALL be ignored (no frame restart, no accumulator clear), except as in REQ-023.
REQ-022 HOLD: in_ready=0; out_valid, out_popsum, out_and, out_or SHALL stay constant until out_ready=1.
REQ-023 HOLD with out_ready=1: start=0 -> IDLE; start=1 same cycle -> ACCUM with accumulators cleared per REQ-016 (back-to-back frames).
REQ-024 Outputs SHALL be registered; out_popsum/out_and/out_or hold the last frame's values when out_valid=0 until a new frame completes.
REQ-025 popsum arithmetic SHALL be unsigned and never overflow given SUM_W.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, in_ready=0, out_valid=0, busy=0, out_popsum=0, out_and=0, out_or=0, cnt=0.
REQ-027 rst mid-frame or in HOLD SHALL discard the partial frame; no summary is ever produced for it.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE/ACCUM/HOLD) and the SUM_W/count-width constant functions.
REQ-029 Popcount SHALL be a separate combinational sub-module, popcount_w, parameterised by DATA_W.

Verification
REQ-030 rst, start, 16 beats in_data=8'hFF, out_ready=1 -> out_valid 1 cycle after 16th beat, popsum=128, and=8'hFF, or=8'hFF.
REQ-031 16 beats 8'h18 with in_valid low every other cycle -> popsum=32, and=8'h18, or=8'h18, out_valid exactly 1 cycle after 16th accepted beat.
REQ-032 Alternate 8'h01/8'h80 ×16, out_ready held 0 for 10 cycles -> popsum=16, and=8'h00, or=8'h81, in_ready=0 and outputs stable throughout HOLD.
REQ-033 rst pulse after 7 beats, then new start and 16 beats 8'h0F -> popsum=64, no summary produced for the aborted frame.
REQ-034 start and out_ready together in HOLD, next frame 16×8'h03 -> immediate ACCUM, popsum=32, and=or=8'h03; start pulses during ACCUM have no effect.
